// File: rtl/cgra_csr_manager_if.sv
// CSR request/response channel between the SNAX-side requester and the CGRA CSR manager.
// master drives requests and response-ready; slave drives request-ready and responses.
interface cgra_csr_manager_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32
);
  logic [DataWidth-1:0] req_data;
  logic [AddrWidth-1:0] req_addr;
  logic                 req_write;
  logic                 req_valid;
  logic                 req_ready;
  logic [DataWidth-1:0] rsp_data;
  logic                 rsp_valid;
  logic                 rsp_ready;

  modport master (
    output req_data, req_addr, req_write, req_valid, rsp_ready,
    input  req_ready, rsp_data, rsp_valid
  );

  modport slave (
    input  req_data, req_addr, req_write, req_valid, rsp_ready,
    output req_ready, rsp_data, rsp_valid
  );
endinterface

// File: rtl/cgra_csr_manager.sv
// CSR responder for the CGRA: config bank, START command, STATUS/PERF, launch sequencing.
// Ports: clk_i/rst_ni, io_csr_req_* / io_csr_rsp_* channel, cgra_cfg_o, cgra_start_o, cgra_done_i.
module cgra_csr_manager #(
  parameter int unsigned NumRwCsr  = 8,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [DataWidth-1:0]          io_csr_req_bits_data_i,
  input  logic [AddrWidth-1:0]          io_csr_req_bits_addr_i,
  input  logic                          io_csr_req_bits_write_i,
  input  logic                          io_csr_req_valid_i,
  output logic                          io_csr_req_ready_o,
  output logic [DataWidth-1:0]          io_csr_rsp_bits_data_o,
  output logic                          io_csr_rsp_valid_o,
  input  logic                          io_csr_rsp_ready_i,
  output logic [NumRwCsr*DataWidth-1:0] cgra_cfg_o,
  output logic                          cgra_start_o,
  input  logic                          cgra_done_i
);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  localparam logic [AddrWidth-1:0] AddrStart  = AddrWidth'(NumRwCsr);
  localparam logic [AddrWidth-1:0] AddrStatus = AddrWidth'(NumRwCsr + 1);
  localparam logic [AddrWidth-1:0] AddrPerf   = AddrWidth'(NumRwCsr + 2);

  state_e               state;
  logic [DataWidth-1:0] cfg_q [NumRwCsr];
  logic [DataWidth-1:0] perf_q;
  logic                 done_q;

  logic                 is_cfg;
  logic                 is_start;
  logic                 is_status;
  logic                 is_perf;
  logic                 run;
  logic                 acc;
  logic                 rd_acc;
  logic                 wr_acc;
  logic [DataWidth-1:0] cfg_rd;
  logic [DataWidth-1:0] status;
  logic [DataWidth-1:0] rd_data;

  assign run       = (state == RUN);
  assign is_cfg    = io_csr_req_bits_addr_i < AddrStart;
  assign is_start  = io_csr_req_bits_addr_i == AddrStart;
  assign is_status = io_csr_req_bits_addr_i == AddrStatus;
  assign is_perf   = io_csr_req_bits_addr_i == AddrPerf;

  // Stall a read while the single response slot is occupied and not
  // draining; stall config writes while a launch is in flight.
  always_comb begin
    io_csr_req_ready_o = 1'b1;
    if (!io_csr_req_bits_write_i && io_csr_rsp_valid_o && !io_csr_rsp_ready_i)
      io_csr_req_ready_o = 1'b0;
    if (io_csr_req_bits_write_i && is_cfg && run)
      io_csr_req_ready_o = 1'b0;
  end

  assign acc    = io_csr_req_valid_i && io_csr_req_ready_o;
  assign rd_acc = acc && !io_csr_req_bits_write_i;
  assign wr_acc = acc && io_csr_req_bits_write_i;

  always_comb begin
    cfg_rd = '0;
    for (int k = 0; k < int'(NumRwCsr); k++)
      if (io_csr_req_bits_addr_i == AddrWidth'(k))
        cfg_rd = cfg_q[k];
  end

  always_comb begin
    status    = '0;
    status[0] = run;
    status[1] = done_q;
  end

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      is_cfg:    rd_data = cfg_rd;
      is_status: rd_data = status;
      is_perf:   rd_data = perf_q;
      default:   rd_data = '0;
    endcase
  end

  for (genvar k = 0; k < int'(NumRwCsr); k++) begin : g_cfg
    assign cgra_cfg_o[k*DataWidth +: DataWidth] = cfg_q[k];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state                  <= IDLE;
      perf_q                 <= '0;
      done_q                 <= 1'b0;
      cgra_start_o           <= 1'b0;
      io_csr_rsp_valid_o     <= 1'b0;
      io_csr_rsp_bits_data_o <= '0;
      for (int k = 0; k < int'(NumRwCsr); k++)
        cfg_q[k] <= '0;
    end else begin
      if (rd_acc) begin
        io_csr_rsp_valid_o     <= 1'b1;
        io_csr_rsp_bits_data_o <= rd_data;
      end else if (io_csr_rsp_ready_i) begin
        io_csr_rsp_valid_o <= 1'b0;
      end

      if (wr_acc && is_cfg)
        for (int k = 0; k < int'(NumRwCsr); k++)
          if (io_csr_req_bits_addr_i == AddrWidth'(k))
            cfg_q[k] <= io_csr_req_bits_data_i;

      cgra_start_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wr_acc && is_start && io_csr_req_bits_data_i[0]) begin
            state        <= RUN;
            cgra_start_o <= 1'b1;
            perf_q       <= '0;
            done_q       <= 1'b0;
          end
        end
        RUN: begin
          // The completion cycle still counts as a run cycle.
          if (perf_q != '1)
            perf_q <= perf_q + 1'b1;
          if (cgra_done_i) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cgra_csr_manager.sv
// Scoreboard bench for cgra_csr_manager: directed CSR traffic, queued
// expected read data, and a monitor that checks each response handshake.
module tb_cgra_csr_manager;
  localparam int S  = 8;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = S * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] cfg;
  logic          start;
  logic          done;

  always #5 clk = ~clk;

  cgra_csr_manager_if #(.DataWidth(DW), .AddrWidth(AW)) bus ();

  cgra_csr_manager #(
    .NumRwCsr(S), .DataWidth(DW), .AddrWidth(AW)
  ) dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .io_csr_req_bits_data_i (bus.req_data),
    .io_csr_req_bits_addr_i (bus.req_addr),
    .io_csr_req_bits_write_i(bus.req_write),
    .io_csr_req_valid_i     (bus.req_valid),
    .io_csr_req_ready_o     (bus.req_ready),
    .io_csr_rsp_bits_data_o (bus.rsp_data),
    .io_csr_rsp_valid_o     (bus.rsp_valid),
    .io_csr_rsp_ready_i     (bus.rsp_ready),
    .cgra_cfg_o             (cfg),
    .cgra_start_o           (start),
    .cgra_done_i            (done)
  );

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [CW-1:0] act,
                       input logic [CW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a response handshake happens at the next posedge
  // whenever valid and ready are both high mid-cycle.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected: got 0x%0h want none", bus.rsp_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (bus.rsp_data !== e) begin
          fails++;
          $display("FAIL rsp_data: got 0x%0h want 0x%0h", bus.rsp_data, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one request starting just after a posedge; returns just
  // after the accepting posedge.
  task automatic csr(input logic wr, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [DW-1:0] exp);
    bit ok = 0;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        if (!wr) exp_q.push_back(exp);
        ok = 1;
        break;
      end
      @(posedge clk);
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL req_timeout: got ready=0 want ready=1 addr=%0d", a);
    end
    cyc();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    done          = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("rst_ready", CW'(bus.req_ready), 1);
    check("rst_rsp_valid", CW'(bus.rsp_valid), 0);
    check("rst_cfg", cfg, 0);
    check("rst_start", CW'(start), 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // 1: status after reset
    csr(0, S + 1, 0, 32'h0);

    // 2: config write then read-back with latency 1
    csr(1, 3, 32'hDEADBEEF, 0);
    @(negedge clk);
    check("cfg3_out", CW'(cfg[127:96]), 32'hDEADBEEF);
    cyc();
    csr(0, 3, 0, 32'hDEADBEEF);
    @(negedge clk);
    check("rd_latency", CW'(bus.rsp_valid), 1);
    cyc();

    // 3: launch, status, perf count
    csr(1, S, 1, 0);
    @(negedge clk);
    check("start_pulse", CW'(start), 1);
    cyc();
    @(negedge clk);
    check("start_one_cycle", CW'(start), 0);
    cyc();
    csr(0, S + 1, 0, 32'h1);
    repeat (6) cyc();
    done = 1'b1;
    cyc();
    done = 1'b0;
    csr(0, S + 1, 0, 32'h2);
    csr(0, S + 2, 0, 32'd10);

    // 4: config frozen during run
    csr(1, S, 1, 0);
    bus.req_write = 1'b1;
    bus.req_addr  = 0;
    bus.req_data  = 32'h12345678;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("run_cfg_stall", CW'(bus.req_ready), 0);
      cyc();
    end
    done = 1'b1;
    @(negedge clk);
    check("stall_on_done", CW'(bus.req_ready), 0);
    check("cfg0_frozen", CW'(cfg[31:0]), 0);
    cyc();
    done = 1'b0;
    @(negedge clk);
    check("ready_after_done", CW'(bus.req_ready), 1);
    cyc();
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("cfg0_written", CW'(cfg[31:0]), 32'h12345678);
    cyc();

    // 5: response back-pressure
    csr(1, 5, 32'h0000A5A5, 0);
    bus.rsp_ready = 1'b0;
    csr(0, 3, 0, 32'hDEADBEEF);
    bus.req_write = 1'b0;
    bus.req_addr  = 5;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rsp_full_stall", CW'(bus.req_ready), 0);
      check("rsp_hold_data", CW'(bus.rsp_data), 32'hDEADBEEF);
      cyc();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("ready_on_drain", CW'(bus.req_ready), 1);
    exp_q.push_back(32'h0000A5A5);
    cyc();
    bus.req_valid = 1'b0;
    cyc();

    // 6: unmapped read, ignored starts, reset mid-run
    csr(0, S + 7, 0, 32'h0);
    csr(1, S, 2, 0);
    @(negedge clk);
    check("start_bit0_clear", CW'(start), 0);
    cyc();
    csr(0, S + 1, 0, 32'h2);
    csr(1, S, 1, 0);
    @(negedge clk);
    check("start_pulse2", CW'(start), 1);
    cyc();
    csr(1, S, 1, 0);
    @(negedge clk);
    check("start_in_run", CW'(start), 0);
    cyc();
    repeat (2) cyc();
    rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", CW'(bus.rsp_valid), 0);
    check("arst_start", CW'(start), 0);
    check("arst_cfg", cfg, 0);
    check("arst_ready", CW'(bus.req_ready), 1);
    cyc();
    rst_n = 1'b1;
    cyc();
    done = 1'b1;
    cyc();
    done = 1'b0;
    csr(0, S + 1, 0, 32'h0);
    csr(0, S + 2, 0, 32'h0);
    repeat (3) cyc();

    check("scoreboard_empty", CW'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
